// File: rtl/sdram_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_arbiter_pkg : shared SDRAM command codes and arbiter state encoding  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package sdram_arbiter_pkg;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_IDLE  = 2'd0;
    localparam cmd_t CMD_READ  = 2'd1;
    localparam cmd_t CMD_WRITE = 2'd2;

    localparam int READ_BURST_LENGTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN0    = 2'd1,
        ST_OWN1    = 2'd2,
        ST_HANDOFF = 2'd3
    } arb_state_t;

    // Swaps a one-hot two-client owner vector to the other client.
    function automatic logic [1:0] other_client(input logic [1:0] onehot);
        return {onehot[0], onehot[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_arbiter_if : client and controller signals around the SDRAM arbiter |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface sdram_arbiter_if
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32
) ();

    logic                  i_C0_Want;
    logic                  i_C1_Want;
    cmd_t                  i_C0_Command;
    cmd_t                  i_C1_Command;
    logic [ADDR_WIDTH-1:0] i_C0_Address;
    logic [ADDR_WIDTH-1:0] i_C1_Address;
    logic [DATA_WIDTH-1:0] i_C0_Write;
    logic [DATA_WIDTH-1:0] i_C1_Write;
    logic                  i_C0_Yield;
    logic                  i_C1_Yield;
    logic                  o_C0_Requested;
    logic                  o_C1_Requested;
    logic                  o_C0_Read_Valid;
    logic                  o_C1_Read_Valid;
    logic                  o_C0_Write_Done;
    logic                  o_C1_Write_Done;
    logic                  i_Data_Read_Valid;
    logic                  i_Data_Write_Done;
    cmd_t                  o_Command;
    logic [ADDR_WIDTH-1:0] o_Data_Address;
    logic [DATA_WIDTH-1:0] o_Data_Write;

    modport slave (
        input  i_C0_Want, i_C1_Want, i_C0_Command, i_C1_Command,
        input  i_C0_Address, i_C1_Address, i_C0_Write, i_C1_Write,
        input  i_C0_Yield, i_C1_Yield, i_Data_Read_Valid, i_Data_Write_Done,
        output o_C0_Requested, o_C1_Requested, o_C0_Read_Valid, o_C1_Read_Valid,
        output o_C0_Write_Done, o_C1_Write_Done, o_Command, o_Data_Address, o_Data_Write
    );

    modport master (
        output i_C0_Want, i_C1_Want, i_C0_Command, i_C1_Command,
        output i_C0_Address, i_C1_Address, i_C0_Write, i_C1_Write,
        output i_C0_Yield, i_C1_Yield, i_Data_Read_Valid, i_Data_Write_Done,
        input  o_C0_Requested, o_C1_Requested, o_C0_Read_Valid, o_C1_Read_Valid,
        input  o_C0_Write_Done, o_C1_Write_Done, o_Command, o_Data_Address, o_Data_Write
    );

endinterface
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_arbiter : tenure-based two-client arbiter for the SDRAM command port |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 22,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           i_Clk,
    input  logic           i_Rst_n,
    sdram_arbiter_if.slave bus
);

    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t            state_q, state_d;
    logic [1:0]            owner_q, owner_d;
    logic [1:0]            req_q, req_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic [1:0]            grant;

    logic [1:0]            want_w;
    logic [1:0]            yield_w;
    cmd_t                  cmd_w   [2];
    logic [ADDR_WIDTH-1:0] addr_w  [2];
    logic [DATA_WIDTH-1:0] wdata_w [2];
    logic [1:0]            owning_w;
    logic                  own_idx;
    logic                  oth_idx;
    logic [1:0]            rv_w;
    logic [1:0]            wd_w;

    assign want_w     = {bus.i_C1_Want, bus.i_C0_Want};
    assign yield_w    = {bus.i_C1_Yield, bus.i_C0_Yield};
    assign cmd_w[0]   = bus.i_C0_Command;
    assign cmd_w[1]   = bus.i_C1_Command;
    assign addr_w[0]  = bus.i_C0_Address;
    assign addr_w[1]  = bus.i_C1_Address;
    assign wdata_w[0] = bus.i_C0_Write;
    assign wdata_w[1] = bus.i_C1_Write;

    assign owning_w = {state_q == ST_OWN1, state_q == ST_OWN0};
    assign own_idx  = (state_q == ST_OWN1);
    assign oth_idx  = ~own_idx;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= 2'b00;
            req_q    <= 2'b11;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            req_q    <= req_d;
            starve_q <= starve_d;
        end
    end

    // During HANDOFF owner_q already names the incoming client.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        req_d    = req_q;
        starve_d = starve_q;
        grant    = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (want_w[0] && !(starve_q == STARVE_MAX && want_w[1])) begin
                    grant = 2'b01;
                end else if (want_w[1]) begin
                    grant = 2'b10;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (cmd_w[own_idx] == CMD_IDLE && (yield_w[own_idx] || !want_w[own_idx])) begin
                    req_d = 2'b11;
                    if (want_w[oth_idx]) begin
                        state_d = ST_HANDOFF;
                        owner_d = other_client(owner_q);
                    end else begin
                        state_d = ST_IDLE;
                        owner_d = 2'b00;
                    end
                end else if (want_w[oth_idx]) begin
                    req_d[own_idx] = 1'b1;
                end
            end
            ST_HANDOFF: begin
                if ((want_w & owner_q) != 2'b00) begin
                    grant = owner_q;
                end else begin
                    state_d = ST_IDLE;
                    owner_d = 2'b00;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant != 2'b00) begin
            owner_d = grant;
            req_d   = ~grant;
            state_d = grant[1] ? ST_OWN1 : ST_OWN0;
            if (grant[1]) begin
                starve_d = '0;
            end else if (want_w[1] && starve_q != STARVE_MAX) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    assign bus.o_Command      = owning_w[0] ? cmd_w[0]   : (owning_w[1] ? cmd_w[1]   : CMD_IDLE);
    assign bus.o_Data_Address = owning_w[0] ? addr_w[0]  : (owning_w[1] ? addr_w[1]  : '0);
    assign bus.o_Data_Write   = owning_w[0] ? wdata_w[0] : (owning_w[1] ? wdata_w[1] : '0);

    // Strobes outside an owned tenure can only be controller faults and are dropped.
    for (genvar n = 0; n < 2; n++) begin : g_client
        assign rv_w[n] = bus.i_Data_Read_Valid & owning_w[n];
        assign wd_w[n] = bus.i_Data_Write_Done & owning_w[n];
    end

    assign bus.o_C0_Read_Valid = rv_w[0];
    assign bus.o_C1_Read_Valid = rv_w[1];
    assign bus.o_C0_Write_Done = wd_w[0];
    assign bus.o_C1_Write_Done = wd_w[1];
    assign bus.o_C0_Requested  = req_q[0];
    assign bus.o_C1_Requested  = req_q[1];

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sdram_arbiter : scoreboard bench for the two-client SDRAM arbiter       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_sdram_arbiter;
    import sdram_arbiter_pkg::*;

    localparam int AW = 22;
    localparam int DW = 32;

    typedef struct packed {
        cmd_t          cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_exp_t;

    logic     clk = 1'b0;
    logic     rst_n;
    int       checks = 0;
    int       errors = 0;
    cmd_exp_t cmd_q [$];
    logic [3:0] stb_q [$];
    cmd_exp_t m_e;
    logic [3:0] m_s;
    logic [3:0] m_x;

    sdram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sdram_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(4)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one client cycle and record what the controller side must show for it.
    task automatic issue(input bit n, input cmd_t c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic rv, input logic wd);
        if (n == 1'b0) begin
            bus.i_C0_Command = c;
            bus.i_C0_Address = a;
            bus.i_C0_Write   = d;
        end else begin
            bus.i_C1_Command = c;
            bus.i_C1_Address = a;
            bus.i_C1_Write   = d;
        end
        bus.i_Data_Read_Valid = rv;
        bus.i_Data_Write_Done = wd;
        if (c != CMD_IDLE) cmd_q.push_back(cmd_exp_t'{cmd: c, addr: a, data: d});
        if (rv || wd) stb_q.push_back(n ? {wd, rv, 2'b00} : {2'b00, wd, rv});
        tick();
    endtask

    // Monitor: every command presented to the controller and every routed strobe is matched in order.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.o_Command != CMD_IDLE) begin
                if (cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: actual %0h required none at %0t", bus.o_Command, $time);
                end else begin
                    m_e = cmd_q.pop_front();
                    chk("o_Command", 64'(bus.o_Command), 64'(m_e.cmd));
                    chk("o_Data_Address", 64'(bus.o_Data_Address), 64'(m_e.addr));
                    chk("o_Data_Write", 64'(bus.o_Data_Write), 64'(m_e.data));
                end
            end
            m_s = {bus.o_C1_Write_Done, bus.o_C1_Read_Valid, bus.o_C0_Write_Done, bus.o_C0_Read_Valid};
            if (m_s != 4'b0000) begin
                if (stb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: actual %0h required none at %0t", m_s, $time);
                end else begin
                    m_x = stb_q.pop_front();
                    chk("strobes", 64'(m_s), 64'(m_x));
                end
            end
        end
    end

    initial begin
        rst_n                 = 1'b0;
        bus.i_C0_Want         = 1'b0;
        bus.i_C1_Want         = 1'b0;
        bus.i_C0_Command      = CMD_IDLE;
        bus.i_C1_Command      = CMD_IDLE;
        bus.i_C0_Address      = 22'h00C00;
        bus.i_C1_Address      = 22'h3F0F0;
        bus.i_C0_Write        = 32'hC0C0_C0C0;
        bus.i_C1_Write        = 32'hC1C1_C1C1;
        bus.i_C0_Yield        = 1'b0;
        bus.i_C1_Yield        = 1'b0;
        bus.i_Data_Read_Valid = 1'b0;
        bus.i_Data_Write_Done = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd", 64'(bus.o_Command), 64'(CMD_IDLE));
        chk("rst_addr", 64'(bus.o_Data_Address), 64'h0);
        chk("rst_wdata", 64'(bus.o_Data_Write), 64'h0);
        chk("rst_req0", 64'(bus.o_C0_Requested), 64'h1);
        chk("rst_req1", 64'(bus.o_C1_Requested), 64'h1);
        rst_n = 1'b1;

        // C0 alone: granted one cycle after Want, command passes straight through.
        tick();
        tick();
        bus.i_C0_Want = 1'b1;
        tick();
        chk("t1_req0", 64'(bus.o_C0_Requested), 64'h0);
        chk("t1_req1", 64'(bus.o_C1_Requested), 64'h1);
        issue(1'b0, CMD_READ, 22'h00ABC, 32'h0, 1'b0, 1'b0);

        // C0 8-word read, C1 asks mid-burst.
        for (int i = 0; i < READ_BURST_LENGTH; i++) begin
            if (i == 2) bus.i_C1_Want = 1'b1;
            issue(1'b0, CMD_READ, 22'h12340, 32'h0, 1'b1, 1'b0);
            if (i == 1) chk("t2_req0_before", 64'(bus.o_C0_Requested), 64'h0);
            if (i == 2) chk("t2_req0_after", 64'(bus.o_C0_Requested), 64'h1);
            if (i == 5) chk("t2_req1_waiting", 64'(bus.o_C1_Requested), 64'h1);
        end
        bus.i_C0_Command      = CMD_IDLE;
        bus.i_Data_Read_Valid = 1'b0;
        bus.i_C0_Yield        = 1'b1;
        tick();
        chk("t2_handoff_cmd", 64'(bus.o_Command), 64'(CMD_IDLE));
        chk("t2_handoff_req0", 64'(bus.o_C0_Requested), 64'h1);
        chk("t2_handoff_req1", 64'(bus.o_C1_Requested), 64'h1);
        bus.i_C0_Yield = 1'b0;
        bus.i_C0_Want  = 1'b0;
        tick();
        chk("t2_own1_req1", 64'(bus.o_C1_Requested), 64'h0);
        chk("t2_own1_req0", 64'(bus.o_C0_Requested), 64'h1);

        // C1 write burst: done strobes must reach C1 only.
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, CMD_WRITE, 22'h2B000, 32'hD000_0000 | 32'(i), 1'b0, 1'b1);
        end
        bus.i_C1_Command      = CMD_IDLE;
        bus.i_Data_Write_Done = 1'b0;
        bus.i_C1_Want         = 1'b0;
        tick();
        chk("t4_idle_req0", 64'(bus.o_C0_Requested), 64'h1);
        chk("t4_idle_req1", 64'(bus.o_C1_Requested), 64'h1);
        bus.i_Data_Read_Valid = 1'b1;
        bus.i_Data_Write_Done = 1'b1;
        #1;
        chk("idle_strobes_dropped", 64'({bus.o_C1_Write_Done, bus.o_C1_Read_Valid,
                                         bus.o_C0_Write_Done, bus.o_C0_Read_Valid}), 64'h0);
        bus.i_Data_Read_Valid = 1'b0;
        bus.i_Data_Write_Done = 1'b0;
        tick();

        // Both want at IDLE: C0 wins four times, the fifth goes to C1, then C0 again.
        for (int r = 1; r <= 6; r++) begin
            bus.i_C0_Want = 1'b1;
            bus.i_C1_Want = 1'b1;
            tick();
            chk($sformatf("t3_round%0d_req0", r), 64'(bus.o_C0_Requested), (r == 5) ? 64'h1 : 64'h0);
            chk($sformatf("t3_round%0d_req1", r), 64'(bus.o_C1_Requested), (r == 5) ? 64'h0 : 64'h1);
            bus.i_C0_Want = 1'b0;
            bus.i_C1_Want = 1'b0;
            tick();
        end

        // C1 withdraws during HANDOFF: back to IDLE with no grant.
        bus.i_C0_Want = 1'b1;
        tick();
        bus.i_C1_Want = 1'b1;
        bus.i_C0_Want = 1'b0;
        tick();
        chk("t6_handoff_cmd", 64'(bus.o_Command), 64'(CMD_IDLE));
        chk("t6_handoff_req1", 64'(bus.o_C1_Requested), 64'h1);
        bus.i_C1_Want = 1'b0;
        tick();
        chk("t6_idle_req1", 64'(bus.o_C1_Requested), 64'h1);
        chk("t6_idle_cmd", 64'(bus.o_Command), 64'(CMD_IDLE));
        tick();
        chk("t6_still_req1", 64'(bus.o_C1_Requested), 64'h1);
        chk("t6_still_req0", 64'(bus.o_C0_Requested), 64'h1);

        // Reset lands in the middle of a C0 read.
        bus.i_C0_Want = 1'b1;
        tick();
        issue(1'b0, CMD_READ, 22'h05555, 32'h0, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_cmd", 64'(bus.o_Command), 64'(CMD_IDLE));
        chk("t5_rst_addr", 64'(bus.o_Data_Address), 64'h0);
        chk("t5_rst_req0", 64'(bus.o_C0_Requested), 64'h1);
        chk("t5_rst_req1", 64'(bus.o_C1_Requested), 64'h1);
        chk("t5_rst_rv0", 64'(bus.o_C0_Read_Valid), 64'h0);
        bus.i_C0_Command      = CMD_IDLE;
        bus.i_C0_Want         = 1'b0;
        bus.i_Data_Read_Valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t5_after_req0", 64'(bus.o_C0_Requested), 64'h1);

        chk("cmd_queue_drained", 64'(cmd_q.size()), 64'h0);
        chk("strobe_queue_drained", 64'(stb_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
